// File: rtl/ysyx22041405_hazard_ctrl.sv
// Hazard controller for the five-stage RV32 pipeline: stall/flush/bubble control plus EX forwarding.
// Build option HAZARD_FWD_EN enables forwarding and WB bypass; without it the block fully interlocks.
module ysyx22041405_hazard_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       id_valid_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_rs1_used_i,
    input  logic       id_rs2_used_i,
    input  logic [4:0] id_rd_i,
    input  logic       id_rd_we_i,
    input  logic       id_is_load_i,
    input  logic       ex_busy_i,
    input  logic       ex_redirect_i,
    output logic       if_id_we_o,
    output logic       if_id_flush_o,
    output logic       id_ex_we_o,
    output logic       id_ex_bubble_o,
    output logic       ex_ls_bubble_o,
    output logic [1:0] fwd_sel1_o,
    output logic [1:0] fwd_sel2_o,
    output logic       id_byp1_o,
    output logic       id_byp2_o
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_LDSTALL = 2'd1;
    localparam logic [1:0] ST_BUSY    = 2'd2;

    logic       ex_v_q, ex_ld_q, ls_v_q, wb_v_q;
    logic [4:0] ex_rd_q, ls_rd_q, wb_rd_q;
    logic [1:0] state_q, state_d;

    logic id_writes;
    logic m_ex1, m_ex2, m_ls1, m_ls2, m_wb1, m_wb2;
    logic load_haz, haz, advance;

    // x0 is never tracked, so a read of x0 can never match anything in flight.
    assign id_writes = id_valid_i & id_rd_we_i & (id_rd_i != 5'd0);

    assign m_ex1 = id_valid_i & id_rs1_used_i & ex_v_q & (ex_rd_q == id_rs1_i);
    assign m_ex2 = id_valid_i & id_rs2_used_i & ex_v_q & (ex_rd_q == id_rs2_i);
    assign m_ls1 = id_valid_i & id_rs1_used_i & ls_v_q & (ls_rd_q == id_rs1_i);
    assign m_ls2 = id_valid_i & id_rs2_used_i & ls_v_q & (ls_rd_q == id_rs2_i);
    assign m_wb1 = id_valid_i & id_rs1_used_i & wb_v_q & (wb_rd_q == id_rs1_i);
    assign m_wb2 = id_valid_i & id_rs2_used_i & wb_v_q & (wb_rd_q == id_rs2_i);

    assign load_haz = ex_ld_q & (m_ex1 | m_ex2);
`ifdef HAZARD_FWD_EN
    assign haz = load_haz;
`else
    assign haz = load_haz | m_ex1 | m_ex2 | m_ls1 | m_ls2 | m_wb1 | m_wb2;
`endif

    always_comb begin
        // NOTE: every output gets a default before the priority chain so no path leaves it unassigned (no latch).
        if_id_we_o     = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_we_o     = 1'b1;
        id_ex_bubble_o = 1'b0;
        ex_ls_bubble_o = 1'b0;
        advance        = 1'b0;
        if (ex_busy_i) begin
            if_id_we_o     = 1'b0;
            id_ex_we_o     = 1'b0;
            ex_ls_bubble_o = 1'b1;
        end else if (ex_redirect_i) begin
            if_id_flush_o  = 1'b1;
            id_ex_bubble_o = 1'b1;
        end else if (haz) begin
            if_id_we_o     = 1'b0;
            id_ex_bubble_o = 1'b1;
        end else begin
            advance = 1'b1;
        end
    end

    always_comb begin
        state_d = ST_RUN;
        if (ex_busy_i) begin
            state_d = ST_BUSY;
        end else if (!ex_redirect_i && haz) begin
            state_d = ST_LDSTALL;
        end
    end

    // While EX is busy the EX entry stays put and a bubble drains into LS behind it.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_v_q  <= 1'b0;
            ex_ld_q <= 1'b0;
            ex_rd_q <= 5'd0;
            ls_v_q  <= 1'b0;
            ls_rd_q <= 5'd0;
            wb_v_q  <= 1'b0;
            wb_rd_q <= 5'd0;
            state_q <= ST_RUN;
        end else begin
            // NOTE: non-blocking assignments so every stage shifts from the pre-edge values.
            state_q <= state_d;
            wb_v_q  <= ls_v_q;
            wb_rd_q <= ls_rd_q;
            if (ex_busy_i) begin
                ls_v_q <= 1'b0;
            end else begin
                ls_v_q  <= ex_v_q;
                ls_rd_q <= ex_rd_q;
                ex_v_q  <= advance & id_writes;
                ex_rd_q <= id_rd_i;
                ex_ld_q <= advance & id_is_load_i;
            end
        end
    end

`ifdef HAZARD_FWD_EN
    logic [1:0] fwd_sel1_q, fwd_sel1_d, fwd_sel2_q, fwd_sel2_d;

    always_comb begin
        fwd_sel1_d = fwd_sel1_q;
        fwd_sel2_d = fwd_sel2_q;
        if (!ex_busy_i) begin
            fwd_sel1_d = 2'd0;
            fwd_sel2_d = 2'd0;
            if (advance) begin
                fwd_sel1_d = m_ex1 ? 2'd1 : (m_ls1 ? 2'd2 : 2'd0);
                fwd_sel2_d = m_ex2 ? 2'd1 : (m_ls2 ? 2'd2 : 2'd0);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fwd_sel1_q <= 2'd0;
            fwd_sel2_q <= 2'd0;
        end else begin
            fwd_sel1_q <= fwd_sel1_d;
            fwd_sel2_q <= fwd_sel2_d;
        end
    end

    assign fwd_sel1_o = fwd_sel1_q;
    assign fwd_sel2_o = fwd_sel2_q;
    assign id_byp1_o  = m_wb1 & ~m_ex1 & ~m_ls1;
    assign id_byp2_o  = m_wb2 & ~m_ex2 & ~m_ls2;

    // The stall cycle always leaves a bubble in EX, so a load hazard cannot recur from LDSTALL.
    a_no_double_ldstall: assert property (@(posedge clk_i) disable iff (!rst_i)
        (state_q == ST_LDSTALL) |-> !load_haz);
`else
    assign fwd_sel1_o = 2'd0;
    assign fwd_sel2_o = 2'd0;
    assign id_byp1_o  = 1'b0;
    assign id_byp2_o  = 1'b0;
`endif

    a_state_legal: assert property (@(posedge clk_i) disable iff (!rst_i)
        (state_q != 2'd3) && (WIDTH > 0));

endmodule

// File: tb/tb_ysyx22041405_hazard_ctrl.sv
// Randomised and directed bench for ysyx22041405_hazard_ctrl against an in-flight instruction list model.
module tb_ysyx22041405_hazard_ctrl;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk_i, rst_i;
    logic       id_valid_i, id_rs1_used_i, id_rs2_used_i, id_rd_we_i, id_is_load_i;
    logic [4:0] id_rs1_i, id_rs2_i, id_rd_i;
    logic       ex_busy_i, ex_redirect_i;
    logic       if_id_we_o, if_id_flush_o, id_ex_we_o, id_ex_bubble_o, ex_ls_bubble_o;
    logic [1:0] fwd_sel1_o, fwd_sel2_o;
    logic       id_byp1_o, id_byp2_o;

    int n_checks = 0;
    int n_errors = 0;

    ysyx22041405_hazard_ctrl #(.WIDTH(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
        .id_rd_i(id_rd_i), .id_rd_we_i(id_rd_we_i), .id_is_load_i(id_is_load_i),
        .ex_busy_i(ex_busy_i), .ex_redirect_i(ex_redirect_i),
        .if_id_we_o(if_id_we_o), .if_id_flush_o(if_id_flush_o),
        .id_ex_we_o(id_ex_we_o), .id_ex_bubble_o(id_ex_bubble_o),
        .ex_ls_bubble_o(ex_ls_bubble_o),
        .fwd_sel1_o(fwd_sel1_o), .fwd_sel2_o(fwd_sel2_o),
        .id_byp1_o(id_byp1_o), .id_byp2_o(id_byp2_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: in-flight writers, index 0 = EX, 1 = LS, 2 = WB (youngest first).
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       ld;
    } ent_t;

    ent_t       pipe_m [3];
    logic [1:0] fs1_m, fs2_m;

    task automatic model_reset();
        for (int k = 0; k < 3; k++) pipe_m[k] = '0;
        fs1_m = 2'd0;
        fs2_m = 2'd0;
    endtask

    // Stage index of the youngest in-flight writer of rs, or 3 if none.
    function automatic int youngest(input logic used, input logic [4:0] rs);
        if (!id_valid_i || !used) return 3;
        for (int k = 0; k < 3; k++)
            if (pipe_m[k].v && pipe_m[k].rd == rs) return k;
        return 3;
    endfunction

    // 1 = busy, 2 = redirect, 3 = hazard stall, 4 = advance
    function automatic int model_case();
        int  y1, y2;
        bit  ld_haz, any;
        y1 = youngest(id_rs1_used_i, id_rs1_i);
        y2 = youngest(id_rs2_used_i, id_rs2_i);
        ld_haz = (y1 == 0 || y2 == 0) && pipe_m[0].ld;
        any    = (y1 != 3) || (y2 != 3);
        if (ex_busy_i) return 1;
        if (ex_redirect_i) return 2;
        if (FWD ? ld_haz : any) return 3;
        return 4;
    endfunction

    function automatic logic [1:0] sel_of(input int y);
        return (y == 0) ? 2'd1 : (y == 1) ? 2'd2 : 2'd0;
    endfunction

    task automatic check_outputs();
        int c, y1, y2;
        c  = model_case();
        y1 = youngest(id_rs1_used_i, id_rs1_i);
        y2 = youngest(id_rs2_used_i, id_rs2_i);
        check("if_id_we",     if_id_we_o,     (c == 1 || c == 3) ? 0 : 1);
        check("if_id_flush",  if_id_flush_o,  (c == 2) ? 1 : 0);
        check("id_ex_we",     id_ex_we_o,     (c == 1) ? 0 : 1);
        check("id_ex_bubble", id_ex_bubble_o, (c == 2 || c == 3) ? 1 : 0);
        check("ex_ls_bubble", ex_ls_bubble_o, (c == 1) ? 1 : 0);
        check("fwd_sel1",     fwd_sel1_o,     fs1_m);
        check("fwd_sel2",     fwd_sel2_o,     fs2_m);
        check("id_byp1",      id_byp1_o,      (FWD && y1 == 2) ? 1 : 0);
        check("id_byp2",      id_byp2_o,      (FWD && y2 == 2) ? 1 : 0);
    endtask

    task automatic model_clock();
        int   c;
        ent_t nxt;
        c = model_case();
        if (c == 1) begin
            pipe_m[2] = pipe_m[1];
            pipe_m[1] = '0;
        end else begin
            nxt.v  = (c == 4) && id_valid_i && id_rd_we_i && (id_rd_i != 5'd0);
            nxt.rd = id_rd_i;
            nxt.ld = (c == 4) && id_is_load_i;
            if (FWD) begin
                fs1_m = (c == 4) ? sel_of(youngest(id_rs1_used_i, id_rs1_i)) : 2'd0;
                fs2_m = (c == 4) ? sel_of(youngest(id_rs2_used_i, id_rs2_i)) : 2'd0;
            end
            pipe_m[2] = pipe_m[1];
            pipe_m[1] = pipe_m[0];
            pipe_m[0] = nxt;
        end
    endtask

    // Inputs change just after a negedge; outputs are sampled 2 time units later.
    task automatic settle();
        #2;
        check_outputs();
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_clock();
        @(negedge clk_i);
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic we, input logic ld);
        id_valid_i = v;  id_rs1_i = rs1; id_rs1_used_i = u1;
        id_rs2_i = rs2;  id_rs2_used_i = u2;
        id_rd_i = rd;    id_rd_we_i = we; id_is_load_i = ld;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        ex_busy_i = 1'b0;
        ex_redirect_i = 1'b0;
    endtask

    task automatic drain();
        idle();
        for (int k = 0; k < 4; k++) begin
            settle();
            tick();
        end
    endtask

    // Hold the current ID instruction until it advances; bounded.
    task automatic issue_until_advance(input string tag, output int stalls);
        bit done;
        done   = 1'b0;
        stalls = 0;
        for (int k = 0; k < 10 && !done; k++) begin
            settle();
            if (if_id_we_o === 1'b1) done = 1'b1;
            else stalls++;
            tick();
        end
        check({tag, "_advanced"}, done, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_if_id_we"}, if_id_we_o, 1);
        check({tag, "_id_ex_we"}, id_ex_we_o, 1);
        check({tag, "_bubbles"}, {if_id_flush_o, id_ex_bubble_o, ex_ls_bubble_o}, 0);
        check({tag, "_fwd_sel"}, {fwd_sel1_o, fwd_sel2_o}, 0);
        check({tag, "_byp"}, {id_byp1_o, id_byp2_o}, 0);
    endtask

    initial begin
        int stalls;
        int busy_left;

        rst_i = 1'b0;
        idle();
        model_reset();
        #3;
        check_reset_outputs("reset");
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;

        // EX-stage forward: addi x5,x0,7 ; add x6,x5,x5
        drain();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        settle(); tick();
        set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
        issue_until_advance("exfwd", stalls);
        check("exfwd_stalls", stalls, FWD ? 0 : 3);
        idle();
        settle();
        check("exfwd_sel1", fwd_sel1_o, FWD ? 1 : 0);
        check("exfwd_sel2", fwd_sel2_o, FWD ? 1 : 0);
        tick();

        // Load-use: lw x5 ; add x6,x5,x0
        drain();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        settle(); tick();
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0);
        issue_until_advance("lduse", stalls);
        check("lduse_stalls", stalls, FWD ? 1 : 3);
        idle();
        settle();
        check("lduse_sel1", fwd_sel1_o, FWD ? 2 : 0);
        tick();

        // Redirect kills an ID instruction writing x7
        drain();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        ex_redirect_i = 1'b1;
        settle();
        check("redir_flush", if_id_flush_o, 1);
        check("redir_bubble", id_ex_bubble_o, 1);
        tick();
        ex_redirect_i = 1'b0;
        set_id(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            settle();
            check("redir_x7_nostall", if_id_we_o, 1);
            check("redir_x7_byp", id_byp1_o, 0);
            tick();
        end
        idle();
        settle();
        check("redir_x7_sel", fwd_sel1_o, 0);
        tick();

        // Busy for 4 cycles with a forwarded instruction sitting in EX
        drain();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        settle(); tick();
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        issue_until_advance("busy_pre", stalls);
        idle();
        ex_busy_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            check("busy_if_id_we", if_id_we_o, 0);
            check("busy_id_ex_we", id_ex_we_o, 0);
            check("busy_ex_ls_bubble", ex_ls_bubble_o, 1);
            check("busy_sel_hold", fwd_sel1_o, FWD ? 1 : 0);
            tick();
        end
        ex_busy_i = 1'b0;
        settle();
        check("busy_release", if_id_we_o, 1);
        tick();

        // WB bypass on x9
        drain();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
        settle(); tick();
        idle();
        settle(); tick();
        settle(); tick();
        set_id(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
        settle();
        check("wb_byp1", id_byp1_o, FWD ? 1 : 0);
        check("wb_nostall", if_id_we_o, FWD ? 1 : 0);
        tick();

        // x0 producer and x0 reader
        drain();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        settle(); tick();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0);
        settle();
        check("x0_nostall", if_id_we_o, 1);
        check("x0_byp", {id_byp1_o, id_byp2_o}, 0);
        tick();
        idle();
        settle();
        check("x0_sel", {fwd_sel1_o, fwd_sel2_o}, 0);
        tick();

        // Asynchronous reset in the middle of a load-use stall
        drain();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        settle(); tick();
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        settle();
        check("rst_pre_stall", if_id_we_o, 0);
        rst_i = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        model_reset();
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        settle();
        check("rst_after_nostall", if_id_we_o, 1);
        tick();

        // Randomised traffic over a small register pool to force collisions
        drain();
        busy_left = 0;
        for (int n = 0; n < 3000; n++) begin
            set_id($urandom_range(0, 9) < 8,
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), $urandom_range(0, 9) < 7,
                   $urandom_range(0, 9) < 3);
            if (busy_left == 0 && $urandom_range(0, 19) == 0) busy_left = $urandom_range(1, 4);
            ex_busy_i = (busy_left != 0);
            if (busy_left != 0) busy_left--;
            ex_redirect_i = ($urandom_range(0, 11) == 0);
            settle();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
